// File: rtl/fb_arbiter_pkg.sv
// Shared framebuffer constants, pixel/state types and the address wrap helper
// used by the framebuffer arbiter and its scanout helpers.
package fb_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned FB_WORDS = H_ACTIVE * V_ACTIVE;

  typedef logic [23:0] pixel_t;

  typedef enum logic {
    IDLE,
    READ
  } fb_arb_state_t;

  // Next linear framebuffer address, wrapping the last word back to 0.
  function automatic int unsigned fb_next_addr(input int unsigned a);
    return (a >= FB_WORDS - 1) ? 32'd0 : a + 32'd1;
  endfunction

endpackage

// File: rtl/fb_arbiter_if.sv
// Bundle of scanout, pixel-writer and framebuffer-RAM signals around fb_arbiter.
// slave = arbiter side, master = scanout/writer/RAM side.
interface fb_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 24
);

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_busy;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_overrun;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    output rd_busy, rd_valid, rd_data, rd_overrun, wr_ready,
           mem_addr, mem_we, mem_wdata
  );

  modport master (
    output rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    input  rd_busy, rd_valid, rd_data, rd_overrun, wr_ready,
           mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/fb_arbiter_rd_pipe.sv
// Valid delay line matching the RAM read latency, with synchronous flush.
// o_any reports that any issued read is still waiting for its data.
module fb_rd_pipe #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_flush,
  input  logic i_valid,
  output logic o_valid,
  output logic o_any
);

  logic [LAT-1:0] r_stage;
  logic [LAT-1:0] w_stage_next;

  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign w_stage_next[gi] = i_valid;
      end else begin : g_tail
        assign w_stage_next[gi] = r_stage[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= '0;
    end else if (i_flush) begin
      r_stage <= '0;
    end else begin
      r_stage <= w_stage_next;
    end
  end

  assign o_valid = r_stage[LAT-1];
  assign o_any   = |r_stage;

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer RAM arbiter: scanout burst reads take strict priority,
// pixel writes stream through a valid/ready handshake whenever no burst is issuing.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 24,
  parameter int BURST   = 16,
  parameter int RAM_LAT = 2
) (
  input  logic         CLOCK_50,
  input  logic         rst_n,
  fb_arbiter_if.slave  bus
);

  localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;

  fb_arb_state_t     r_state;
  logic [BEAT_W-1:0] r_beat;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_overrun;

  logic w_issue;
  logic w_drain;
  logic w_busy;
  logic w_rd_valid;
  logic w_rd_accept;
  logic w_wr_fire;
  logic w_wr_in_range;
  logic w_last_beat;

  // Every READ cycle puts one read address on the RAM port.
  assign w_issue       = (r_state == READ);
  assign w_busy        = w_issue | w_drain;
  assign w_rd_accept   = bus.rd_req && (r_state == IDLE) && !w_busy;
  assign bus.wr_ready  = (r_state == IDLE) && !bus.rd_req;
  assign w_wr_fire     = bus.wr_valid && bus.wr_ready;
  assign w_wr_in_range = (32'(bus.wr_addr) < FB_WORDS);
  assign w_last_beat   = (r_beat == BEAT_W'(BURST - 1));

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_beat      <= '0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      if (bus.rd_req && !w_rd_accept) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_rd_accept) begin
            r_state    <= READ;
            r_mem_addr <= bus.rd_addr;
            r_beat     <= '0;
          end else if (w_wr_fire && w_wr_in_range) begin
            // Out-of-range pixels are still handshaken, just never written.
            r_mem_we    <= 1'b1;
            r_mem_addr  <= bus.wr_addr;
            r_mem_wdata <= bus.wr_data;
          end
        end
        READ: begin
          r_beat <= r_beat + 1'b1;
          if (w_last_beat) begin
            r_state <= IDLE;
          end else begin
            r_mem_addr <= ADDR_W'(fb_next_addr(32'(r_mem_addr)));
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  fb_rd_pipe #(
    .LAT (RAM_LAT)
  ) u_rd_pipe (
    .clk     (CLOCK_50),
    .rst_n   (rst_n),
    .i_flush (1'b0),
    .i_valid (w_issue),
    .o_valid (w_rd_valid),
    .o_any   (w_drain)
  );

  assign bus.rd_busy    = w_busy;
  assign bus.rd_valid   = w_rd_valid;
  assign bus.rd_data    = w_rd_valid ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.rd_overrun = r_overrun;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: a cycle-window reference model plus a
// behavioural 2-cycle-latency RAM with mem[a]=a preload semantics.
module tb_fb_arbiter;

  localparam int ADDR_W  = 19;
  localparam int DATA_W  = 24;
  localparam int BURST   = 16;
  localparam int RAM_LAT = 2;
  localparam int FBW     = 307200;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fb_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .BURST   (BURST),
    .RAM_LAT (RAM_LAT)
  ) u_dut (
    .CLOCK_50 (clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  // Behavioural RAM: unwritten words read back as their own address.
  logic [23:0] ram     [0:FBW-1];
  bit          ram_set [0:FBW-1];
  logic [23:0] ram_p1 = 24'h0;

  always @(posedge clk) begin
    if (int'(bus.mem_addr) < FBW)
      ram_p1 <= ram_set[bus.mem_addr] ? ram[bus.mem_addr] : 24'(bus.mem_addr);
    else
      ram_p1 <= 24'h0;
    bus.mem_rdata <= ram_p1;
    if (bus.mem_we && int'(bus.mem_addr) < FBW) begin
      ram[bus.mem_addr]     <= bus.mem_wdata;
      ram_set[bus.mem_addr] <= 1'b1;
    end
  end

  // Reference model state: windows are derived from the accepted request cycle.
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc  = -1000;
  int acc_addr = 0;
  bit ovr      = 1'b0;
  bit pend_we  = 1'b0;
  int pend_addr = 0;
  int pend_data = 0;
  int mdl_mem [int];
  int snap [BURST];

  typedef struct {
    logic [18:0] addr;
    logic [23:0] data;
    logic        we;
  } wvec_t;
  wvec_t tbl [12];

  function automatic int wrap(input int a);
    return a % FBW;
  endfunction

  function automatic int mdl_rd(input int a);
    return mdl_mem.exists(a) ? mdl_mem[a] : a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    acc_cyc = -1000;
    ovr     = 1'b0;
    pend_we = 1'b0;
  endtask

  // Check one cycle against the model (at negedge), advance the model, move to next cycle.
  task automatic step();
    int d;
    bit in_read, busy, vld;
    int exp_data;
    @(negedge clk);
    d        = cyc - acc_cyc;
    in_read  = (d >= 1) && (d <= BURST);
    busy     = (d >= 1) && (d <= BURST + RAM_LAT);
    vld      = (d >= 1 + RAM_LAT) && (d <= BURST + RAM_LAT);
    exp_data = vld ? snap[d-1-RAM_LAT] : 0;
    chk("rd_busy",    32'(bus.rd_busy),    32'(busy));
    chk("rd_valid",   32'(bus.rd_valid),   32'(vld));
    chk("rd_data",    32'(bus.rd_data),    exp_data);
    chk("rd_overrun", 32'(bus.rd_overrun), 32'(ovr));
    chk("wr_ready",   32'(bus.wr_ready),   32'(!in_read && !bus.rd_req));
    chk("mem_we",     32'(bus.mem_we),     32'(pend_we));
    if (in_read)
      chk("mem_addr_rd", 32'(bus.mem_addr), wrap(acc_addr + d - 1));
    if (pend_we) begin
      chk("mem_addr_wr", 32'(bus.mem_addr),  pend_addr);
      chk("mem_wdata",   32'(bus.mem_wdata), pend_data);
      mdl_mem[pend_addr] = pend_data;
    end
    pend_we = 1'b0;
    if (bus.rd_req) begin
      if (busy) begin
        ovr = 1'b1;
      end else begin
        acc_cyc  = cyc;
        acc_addr = int'(bus.rd_addr);
        for (int k = 0; k < BURST; k++) snap[k] = mdl_rd(wrap(acc_addr + k));
      end
    end else if (!in_read && bus.wr_valid && int'(bus.wr_addr) < FBW) begin
      pend_we   = 1'b1;
      pend_addr = int'(bus.wr_addr);
      pend_data = int'(bus.wr_data);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rd_busy"},    32'(bus.rd_busy),    0);
    chk({tag, "_rd_valid"},   32'(bus.rd_valid),   0);
    chk({tag, "_rd_data"},    32'(bus.rd_data),    0);
    chk({tag, "_rd_overrun"}, 32'(bus.rd_overrun), 0);
    chk({tag, "_mem_addr"},   32'(bus.mem_addr),   0);
    chk({tag, "_mem_we"},     32'(bus.mem_we),     0);
    chk({tag, "_mem_wdata"},  32'(bus.mem_wdata),  0);
    chk({tag, "_wr_ready"},   32'(bus.wr_ready),   1);
  endtask

  task automatic burst(input int addr, input int cycles);
    bus.rd_req  = 1'b1;
    bus.rd_addr = ADDR_W'(addr);
    step();
    bus.rd_req  = 1'b0;
    repeat (cycles) step();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) tbl[i] = '{19'(1000 + i), 24'(24'hA00000 + i), 1'b1};
    tbl[8]  = '{19'd307200, 24'h777777, 1'b0};
    tbl[9]  = '{19'd307199, 24'h123456, 1'b1};
    tbl[10] = '{19'd0,      24'hFFFFFF, 1'b1};
    tbl[11] = '{19'd524287, 24'h0F0F0F, 1'b0};

    bus.rd_req   = 1'b0;
    bus.rd_addr  = '0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    rst_n = 1'b1;
    #1;
    chk("wr_ready_after_rst", 32'(bus.wr_ready), 1);
    @(posedge clk);
    #1;

    // Burst at 100 competing with a held write; the write lands after the burst.
    bus.rd_req   = 1'b1;
    bus.rd_addr  = 19'd100;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 19'd500;
    bus.wr_data  = 24'h5A5A5A;
    step();
    bus.rd_req = 1'b0;
    repeat (17) step();
    bus.wr_valid = 1'b0;
    chk("wr_after_burst_we",   32'(bus.mem_we),   1);
    chk("wr_after_burst_addr", 32'(bus.mem_addr), 500);
    repeat (4) step();

    // Table of back-to-back writes, including out-of-range addresses.
    for (int i = 0; i < 12; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr  = tbl[i].addr;
      bus.wr_data  = tbl[i].data;
      step();
      chk("tbl_we", 32'(bus.mem_we), 32'(tbl[i].we));
      if (tbl[i].we) begin
        chk("tbl_addr",  32'(bus.mem_addr),  32'(tbl[i].addr));
        chk("tbl_wdata", 32'(bus.mem_wdata), 32'(tbl[i].data));
      end
    end
    bus.wr_valid = 1'b0;
    repeat (2) step();

    // Read back the written pixels.
    burst(1000, 20);

    // Wrapping burst with an ignored request during the data drain.
    burst(307195, 16);
    bus.rd_req  = 1'b1;
    bus.rd_addr = 19'd5;
    step();
    bus.rd_req = 1'b0;
    repeat (4) step();
    chk("overrun_sticky", 32'(bus.rd_overrun), 1);

    // Asynchronous reset while beat 7 is on the RAM port.
    burst(2000, 7);
    #2 rst_n = 1'b0;
    #1;
    check_reset("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (6) step();
    burst(3000, 20);

    // Randomised traffic against the model.
    repeat (400) begin
      bus.rd_req   = ($urandom_range(0, 15) == 0);
      bus.rd_addr  = ADDR_W'($urandom_range(0, FBW - 1));
      bus.wr_valid = $urandom_range(0, 1) == 1;
      bus.wr_addr  = ($urandom_range(0, 9) == 0) ? ADDR_W'($urandom_range(FBW, 524287))
                                                 : ADDR_W'($urandom_range(0, FBW - 1));
      bus.wr_data  = DATA_W'($urandom);
      step();
    end
    bus.rd_req   = 1'b0;
    bus.wr_valid = 1'b0;
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Single-port framebuffer RAM arbiter between the VGA scanout path and the pixel writer. Scanout issues line-prefetch burst reads at strict priority. The writer streams single-pixel writes through a valid/ready handshake whenever no burst is being issued. Sits between the `vga` timing/scanout logic and the on-chip framebuffer RAM, all in the `CLOCK_50` domain.

## Interface
Parameters:
- `ADDR_W`, 19, word address width (640×480 = 307200 words)
- `DATA_W`, 24, pixel width, RGB888 packed {R,G,B}
- `BURST`, 16, words per scanout read burst
- `RAM_LAT`, 2, RAM read latency in cycles, addr-to-data, ≥1

Ports:
- `CLOCK_50  in   1       system clock; sole clock`
- `rst_n     in   1       asynchronous, active-low reset`
- `rd_req    in   1       scanout burst request; single-cycle pulse`
- `rd_addr   in   ADDR_W  burst start address, sampled with rd_req`
- `rd_busy   out  1       burst in flight (issue or data drain)`
- `rd_valid  out  1       rd_data valid this cycle`
- `rd_data   out  DATA_W  returned pixel`
- `rd_overrun out 1       sticky: rd_req arrived while rd_busy`
- `wr_valid  in   1       writer has a pixel`
- `wr_ready  out  1       arbiter accepts pixel this cycle`
- `wr_addr   in   ADDR_W  write address`
- `wr_data   in   DATA_W  write pixel`
- `mem_addr  out  ADDR_W  RAM address, registered`
- `mem_we    out  1       RAM write enable, registered`
- `mem_wdata out  DATA_W  RAM write data, registered`
- `mem_rdata in   DATA_W  RAM read data, valid RAM_LAT cycles after mem_addr`

## Operation
- States: IDLE, READ.
  - IDLE: on `rd_req`, go to READ, load address counter = `rd_addr` and beat counter = 0.
  - READ: issue one read per cycle; after beat `BURST-1`, return to IDLE.
- `wr_ready = (state == IDLE) && !rd_req`, combinational. On a read request cycle, the read wins.
- Write handshake at `wr_valid && wr_ready`. The next cycle drives `mem_we=1`, `mem_addr=wr_addr`, `mem_wdata=wr_data`.
- Writes stream one per cycle while in IDLE. Writes are also permitted during the read-data drain, because reads are already issued to the pipelined RAM.
- Burst addresses increment by 1 and wrap modulo `FB_WORDS` (307199 → 0).
- `rd_valid` comes from a `RAM_LAT`-deep valid delay line fed by the read-issue strobe. `rd_data = mem_rdata` while `rd_valid`, else 0.
- `rd_busy` is high from the first issue cycle until the cycle of the last `rd_valid`, inclusive.
- Overrun: `rd_req` while `rd_busy`, or while in READ, is ignored and sets `rd_overrun`. The flag clears only on reset.
- Out-of-range address (`wr_addr ≥ FB_WORDS`): the write is accepted and dropped (`mem_we` stays 0).
- Reset, including mid-burst: state=IDLE, counters=0, delay line flushed. All outputs 0: `rd_busy`, `rd_valid`, `rd_data`, `rd_overrun`, `mem_addr`, `mem_we`, `mem_wdata`. `wr_ready` follows its equation (1 once `rst_n` is high and `rd_req` is low).

## Timing
- `rd_req` seen at cycle 0:
  - `mem_addr = rd_addr + k` at cycle 1+k, for k = 0..BURST-1.
  - `rd_valid` high on cycles 1+RAM_LAT through BURST+RAM_LAT.
  - `rd_busy` high on cycles 1 through BURST+RAM_LAT.
- Write accepted at cycle 0 → RAM write on cycle 1.
- The earliest next `rd_req` may be accepted the cycle after `rd_busy` falls.

## Structure
- Package `fb_pkg` holds:
  - `FB_WORDS = 307200`, `H_ACTIVE = 640`, `V_ACTIVE = 480`
  - `typedef logic [23:0] pixel_t`
  - `typedef enum {IDLE, READ} fb_arb_state_t`
- Sub-module `fb_rd_pipe`: parameterised `RAM_LAT` valid delay line with synchronous flush. It is shared with future scanout FIFOs.

## Test plan
- Reset, then `rd_req` with `rd_addr=100`, RAM preloaded mem[a]=a → `mem_addr` 100..115 on cycles 1..16; `rd_data` 100..115 with `rd_valid` on cycles 3..18 (RAM_LAT=2); `rd_busy` falls after cycle 18.
- `wr_valid` held with `rd_req` in the same cycle → `wr_ready=0`, the read wins. The write completes on the first IDLE cycle after beat 15.
- Burst at `rd_addr=307195` → addresses 307195..307199, then 0..10.
- 8 back-to-back writes in IDLE → 8 consecutive `mem_we` cycles, data in order. Write to 307200 → accepted, `mem_we=0`.
- Second `rd_req` during drain → `rd_overrun=1` and stays set; the burst is unaffected.
- `rst_n` low at beat 7 → all outputs 0 asynchronously; after release, `rd_valid` stays 0 and a new burst runs cleanly.
